// File: rtl/au_dec_sched.sv
// ---------------------------------------------------------------------------
// au_dec_sched
//   Round-robin scheduler that time-shares a single au_dec decrementer among
//   NCH countdown channels. A channel is loaded with a start value and
//   decremented once per grant until it reaches zero. Completions are then
//   reported, lowest channel first, through a ready/valid port.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ld_valid/ld_ready     load handshake; ld_ch selects channel, ld_val count
//   done_valid/done_ready completion handshake; done_ch is the channel index
//   rd_ch/rd_cnt          combinational read-back of one channel's count
//   active                per-channel RUN flags
//   busy                  any channel in RUN or DONE
//
// Channel states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | free, accepts a load
//   RUN     | counting down, competes for the decrementer
//   DONE    | reached zero, waiting for the completion handshake
// ---------------------------------------------------------------------------

// Shared decrementer. ARCH selects the implementation only; both give a-1.
module au_dec #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] z
);
  generate
    if (ARCH == 0) begin : g_sub
      assign z = a - WIDTH'(1);
    end else begin : g_ripple
      // Explicit borrow chain: a bit flips while every lower bit is zero.
      logic [WIDTH-1:0] w_borrow;
      assign w_borrow[0] = 1'b1;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign z[i] = a[i] ^ w_borrow[i];
        if (i < WIDTH - 1) begin : g_chain
          assign w_borrow[i+1] = w_borrow[i] & ~a[i];
        end
      end
    end
  endgenerate
endmodule

module au_dec_sched #(
  parameter  int WIDTH = 8,
  parameter  int ARCH  = 0,
  parameter  int NCH   = 4,
  localparam int CW    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [CW-1:0]    ld_ch,
  input  logic [WIDTH-1:0] ld_val,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [CW-1:0]    done_ch,
  input  logic [CW-1:0]    rd_ch,
  output logic [WIDTH-1:0] rd_cnt,
  output logic [NCH-1:0]   active,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  ch_state_t        r_st  [NCH];
  logic [WIDTH-1:0] r_cnt [NCH];
  logic [CW-1:0]    r_ptr;
  logic             r_dlock;
  logic [CW-1:0]    r_dch;

  logic             w_gnt_vld;
  logic [CW-1:0]    w_gnt;
  logic [CW:0]      w_sum;
  logic [WIDTH-1:0] w_dec_a;
  logic [WIDTH-1:0] w_dec_z;
  logic [CW-1:0]    w_low_done;
  logic             w_ld_fire;
  logic             w_done_fire;

  // Round-robin search: first RUN channel at or after r_ptr, modulo NCH.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_sum     = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sum = {1'b0, r_ptr} + (CW+1)'(i);
      if (w_sum >= (CW+1)'(NCH)) begin
        w_sum = w_sum - (CW+1)'(NCH);
      end
      if (!w_gnt_vld && (r_st[w_sum[CW-1:0]] == ST_RUN)) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_sum[CW-1:0];
      end
    end
  end

  // Per-channel decode: operand mux, read-back, load acceptance, flags.
  // Indices are matched against each channel so out-of-range selects
  // simply read as zero / not ready.
  always_comb begin
    w_dec_a    = '0;
    rd_cnt     = '0;
    ld_ready   = 1'b0;
    active     = '0;
    busy       = 1'b0;
    done_valid = 1'b0;
    w_low_done = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_gnt == CW'(i)) begin
        w_dec_a = r_cnt[i];
      end
      if (rd_ch == CW'(i)) begin
        rd_cnt = r_cnt[i];
      end
      if ((ld_ch == CW'(i)) && (r_st[i] == ST_IDLE)) begin
        ld_ready = 1'b1;
      end
      active[i] = (r_st[i] == ST_RUN);
      if (r_st[i] != ST_IDLE) begin
        busy = 1'b1;
      end
      // Descending scan leaves the lowest DONE index in w_low_done.
      if (r_st[i] == ST_DONE) begin
        done_valid = 1'b1;
        w_low_done = CW'(i);
      end
    end
  end

  // Once a completion is offered its index is frozen until accepted, so a
  // lower channel finishing meanwhile cannot change done_ch under the consumer.
  assign done_ch     = r_dlock ? r_dch : w_low_done;
  assign w_ld_fire   = ld_valid && ld_ready;
  assign w_done_fire = done_valid && done_ready;

  au_dec #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_au_dec (
    .a (w_dec_a),
    .z (w_dec_z)
  );

  // Load, grant and handshake target channels in IDLE, RUN and DONE
  // respectively, so all three can land on the same edge without conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_st[i]  <= ST_IDLE;
        r_cnt[i] <= '0;
      end
      r_ptr   <= '0;
      r_dlock <= 1'b0;
      r_dch   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        case (r_st[i])
          ST_IDLE: begin
            if (w_ld_fire && (ld_ch == CW'(i))) begin
              r_cnt[i] <= ld_val;
              r_st[i]  <= (ld_val != '0) ? ST_RUN : ST_DONE;
            end
          end
          ST_RUN: begin
            // Grants only ever see count >= 1, so the count cannot wrap.
            if (w_gnt_vld && (w_gnt == CW'(i))) begin
              r_cnt[i] <= w_dec_z;
              if (r_cnt[i] == WIDTH'(1)) begin
                r_st[i] <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (w_done_fire && (done_ch == CW'(i))) begin
              r_st[i] <= ST_IDLE;
            end
          end
          default: r_st[i] <= ST_IDLE;
        endcase
      end

      if (w_gnt_vld) begin
        r_ptr <= (w_gnt == CW'(NCH - 1)) ? '0 : w_gnt + CW'(1);
      end

      r_dlock <= done_valid && !done_ready;
      r_dch   <= done_ch;
    end
  end

endmodule

// File: tb/tb_au_dec_sched.sv
module tb_au_dec_sched;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [CW-1:0]    ld_ch = '0;
  logic [WIDTH-1:0] ld_val = '0;
  logic             done_valid;
  logic             done_ready = 1'b0;
  logic [CW-1:0]    done_ch;
  logic [CW-1:0]    rd_ch = '0;
  logic [WIDTH-1:0] rd_cnt;
  logic [NCH-1:0]   active;
  logic             busy;

  au_dec_sched #(.WIDTH(WIDTH), .ARCH(0), .NCH(NCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_ch      (ld_ch),
    .ld_val     (ld_val),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_ch    (done_ch),
    .rd_ch      (rd_ch),
    .rd_cnt     (rd_cnt),
    .active     (active),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ld_valid   = 1'($urandom_range(1));
    ld_ch      = 2'($urandom_range(3));
    ld_val     = 8'($urandom_range(255));
    done_ready = 1'($urandom_range(1));
    rd_ch      = 2'($urandom_range(3));
    repeat (3) @(posedge clk);
    #1;
    ld_ch = '0;
    rd_ch = '0;
    #1;
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_done_ch", int'(done_ch), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ld_ready", int'(ld_ready), 1);
    chk("rst_rd_cnt", int'(rd_cnt), 0);
    ld_valid   = 1'b0;
    ld_val     = '0;
    done_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_counts(string nm, int c0, int c1, int c2, int c3);
    int exp [NCH];
    exp = '{c0, c1, c2, c3};
    for (int k = 0; k < NCH; k++) begin
      rd_ch = 2'(k);
      #1;
      chk($sformatf("%s_ch%0d", nm, k), int'(rd_cnt), exp[k]);
    end
  endtask

  typedef struct {
    int lv, lch, lval, dr, rch;
    int e_lr, e_dv, e_dch, e_rd, e_act, e_busy;
  } vec_t;
  vec_t vecs [14];

  // Reference model for the random phase.
  int m_st [NCH];   // 0 idle, 1 run, 2 done
  int m_cnt [NCH];
  int m_ptr;
  bit m_hold;
  int m_hch;
  int outst [NCH];

  initial begin
    int e_lr, e_dv, e_dch, e_act, e_busy, low, g, lf;
    int n_loads, n_done, early;
    bit hs;

    //          lv lch lval dr rch | lr dv dch rd act busy
    vecs[0]  = '{1, 0, 5,   1, 0,   1, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,   1, 0,   0, 0, 0, 5, 1, 1};
    vecs[2]  = '{0, 0, 0,   1, 0,   0, 0, 0, 4, 1, 1};
    vecs[3]  = '{0, 0, 0,   1, 0,   0, 0, 0, 3, 1, 1};
    vecs[4]  = '{0, 0, 0,   1, 0,   0, 0, 0, 2, 1, 1};
    vecs[5]  = '{0, 0, 0,   1, 0,   0, 0, 0, 1, 1, 1};
    vecs[6]  = '{0, 0, 0,   1, 0,   0, 1, 0, 0, 0, 1};
    vecs[7]  = '{1, 2, 0,   1, 2,   1, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 2, 3,   0, 2,   0, 1, 2, 0, 0, 1};
    vecs[9]  = '{1, 2, 3,   1, 2,   0, 1, 2, 0, 0, 1};
    vecs[10] = '{1, 2, 1,   1, 2,   1, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0,   1, 2,   1, 0, 0, 1, 4, 1};
    vecs[12] = '{0, 0, 0,   1, 2,   1, 1, 2, 0, 0, 1};
    vecs[13] = '{0, 0, 0,   1, 2,   1, 0, 0, 0, 0, 0};

    // Single channel, zero-value load, stall in the handshake cycle.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      ld_valid   = 1'(vecs[i].lv);
      ld_ch      = 2'(vecs[i].lch);
      ld_val     = 8'(vecs[i].lval);
      done_ready = 1'(vecs[i].dr);
      rd_ch      = 2'(vecs[i].rch);
      #1;
      chk($sformatf("vec%0d_ld_ready", i), int'(ld_ready), vecs[i].e_lr);
      chk($sformatf("vec%0d_done_valid", i), int'(done_valid), vecs[i].e_dv);
      if (vecs[i].e_dv != 0)
        chk($sformatf("vec%0d_done_ch", i), int'(done_ch), vecs[i].e_dch);
      chk($sformatf("vec%0d_rd_cnt", i), int'(rd_cnt), vecs[i].e_rd);
      chk($sformatf("vec%0d_active", i), int'(active), vecs[i].e_act);
      chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].e_busy);
      step();
    end

    // Fairness: four channels loaded with 3 on consecutive edges.
    do_reset();
    ld_valid = 1'b1;
    ld_val   = 8'd3;
    for (int k = 0; k < NCH; k++) begin
      ld_ch = 2'(k);
      step();
    end
    ld_valid = 1'b0;
    step(); chk_counts("fair_e4", 2, 2, 2, 2);
    chk("fair_active", int'(active), 15);
    step(); chk_counts("fair_e5", 1, 2, 2, 2);
    step(); chk_counts("fair_e6", 1, 1, 2, 2);
    step(); chk_counts("fair_e7", 1, 1, 1, 2);
    step(); chk_counts("fair_e8", 1, 1, 1, 1);
    for (int k = 0; k < NCH; k++) begin
      step();
      chk($sformatf("fair_dv%0d", k), int'(done_valid), 1);
      chk($sformatf("fair_dch%0d", k), int'(done_ch), k);
    end
    step();
    chk("fair_end_dv", int'(done_valid), 0);
    chk("fair_end_busy", int'(busy), 0);

    // Backpressure: ch1=1, ch2=2 with done_ready low.
    do_reset();
    done_ready = 1'b0;
    ld_valid = 1'b1; ld_ch = 2'd1; ld_val = 8'd1;
    step();
    ld_ch = 2'd2; ld_val = 8'd2;
    step();
    ld_valid = 1'b0;
    chk("bp_first_dv", int'(done_valid), 1);
    chk("bp_first_dch", int'(done_ch), 1);
    step(); step();
    rd_ch = 2'd2;
    ld_valid = 1'b1; ld_ch = 2'd1; ld_val = 8'd4;
    #1;
    chk("bp_ch2_cnt", int'(rd_cnt), 0);
    chk("bp_active", int'(active), 0);
    chk("bp_busy", int'(busy), 1);
    chk("bp_stall_lr", int'(ld_ready), 0);
    step(); step();
    rd_ch = 2'd1;
    #1;
    chk("bp_hold_dch", int'(done_ch), 1);
    chk("bp_hold_lr", int'(ld_ready), 0);
    chk("bp_ch1_cnt", int'(rd_cnt), 0);
    ld_valid = 1'b0;
    done_ready = 1'b1;
    #1;
    chk("bp_rel_dch1", int'(done_ch), 1);
    step();
    chk("bp_rel_dv2", int'(done_valid), 1);
    chk("bp_rel_dch2", int'(done_ch), 2);
    step();
    chk("bp_rel_end_dv", int'(done_valid), 0);
    chk("bp_rel_end_busy", int'(busy), 0);
    // A lower channel finishing while ch2 is offered must not move done_ch.
    done_ready = 1'b0;
    ld_valid = 1'b1; ld_ch = 2'd2; ld_val = 8'd0;
    step();
    ld_ch = 2'd0;
    #1;
    chk("bp_lock_dv", int'(done_valid), 1);
    chk("bp_lock_dch_a", int'(done_ch), 2);
    step();
    ld_valid = 1'b0;
    #1;
    chk("bp_lock_dch_b", int'(done_ch), 2);
    done_ready = 1'b1;
    step();
    chk("bp_lock_next_dch", int'(done_ch), 0);
    chk("bp_lock_next_dv", int'(done_valid), 1);
    step();
    chk("bp_lock_end_dv", int'(done_valid), 0);

    // All-ones start value: 255 grants, no wrap.
    do_reset();
    done_ready = 1'b0;
    ld_valid = 1'b1; ld_ch = 2'd3; ld_val = 8'hFF; rd_ch = 2'd3;
    step();
    ld_valid = 1'b0;
    #1;
    chk("ff_start", int'(rd_cnt), 255);
    early = 0;
    for (int e = 1; e < 255; e++) begin
      step();
      if (done_valid) early++;
      if (e == 1)   chk("ff_e1", int'(rd_cnt), 254);
      if (e == 254) chk("ff_e254", int'(rd_cnt), 1);
    end
    chk("ff_early_done", early, 0);
    step();
    chk("ff_dv", int'(done_valid), 1);
    chk("ff_dch", int'(done_ch), 3);
    chk("ff_zero", int'(rd_cnt), 0);
    step(); step(); step();
    chk("ff_nowrap", int'(rd_cnt), 0);
    chk("ff_active", int'(active), 0);
    done_ready = 1'b1;
    step();
    chk("ff_end_busy", int'(busy), 0);

    // Reset while counting at 7: no completion afterwards.
    do_reset();
    ld_valid = 1'b1; ld_ch = 2'd0; ld_val = 8'd10; rd_ch = 2'd0;
    step();
    ld_valid = 1'b0;
    step(); step(); step();
    chk("mid_cnt7", int'(rd_cnt), 7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt", int'(rd_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    early = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done_valid || busy) early++;
    end
    chk("mid_no_done", early, 0);

    // Random loads and handshakes against a cycle model.
    do_reset();
    for (int k = 0; k < NCH; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; outst[k] = 0;
    end
    m_ptr = 0; m_hold = 1'b0; m_hch = 0;
    n_loads = 0; n_done = 0;
    for (int c = 0; c < 3000; c++) begin
      ld_valid   = ($urandom_range(99) < 40);
      ld_ch      = 2'($urandom_range(3));
      ld_val     = 8'($urandom_range(7));
      done_ready = ($urandom_range(99) < 50);
      rd_ch      = 2'($urandom_range(3));
      #1;
      e_lr = (m_st[ld_ch] == 0) ? 1 : 0;
      e_dv = 0; low = -1; e_act = 0; e_busy = 0;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (m_st[k] == 2) begin e_dv = 1; low = k; end
        if (m_st[k] == 1) e_act |= (1 << k);
        if (m_st[k] != 0) e_busy = 1;
      end
      e_dch = m_hold ? m_hch : ((low < 0) ? 0 : low);
      chk("rnd_ld_ready", int'(ld_ready), e_lr);
      chk("rnd_done_valid", int'(done_valid), e_dv);
      if (e_dv != 0) chk("rnd_done_ch", int'(done_ch), e_dch);
      chk("rnd_rd_cnt", int'(rd_cnt), m_cnt[rd_ch]);
      chk("rnd_active", int'(active), e_act);
      chk("rnd_busy", int'(busy), e_busy);
      if (ld_valid && ld_ready) begin
        chk("rnd_load_dup", outst[ld_ch], 0);
        outst[ld_ch]++;
        n_loads++;
      end
      if (done_valid && done_ready) begin
        chk("rnd_done_owed", outst[done_ch], 1);
        outst[done_ch]--;
        n_done++;
      end
      g = -1;
      for (int k = 0; k < NCH; k++) begin
        if (g < 0 && m_st[(m_ptr + k) % NCH] == 1) g = (m_ptr + k) % NCH;
      end
      lf = (ld_valid && e_lr != 0) ? 1 : 0;
      hs = (e_dv != 0) && done_ready;
      if (g >= 0) begin
        m_cnt[g]--;
        if (m_cnt[g] == 0) m_st[g] = 2;
        m_ptr = (g + 1) % NCH;
      end
      if (hs) m_st[e_dch] = 0;
      if (lf != 0) begin
        m_cnt[ld_ch] = int'(ld_val);
        m_st[ld_ch]  = (ld_val != 0) ? 1 : 2;
      end
      m_hold = (e_dv != 0) && !done_ready;
      m_hch  = e_dch;
      step();
    end
    ld_valid   = 1'b0;
    done_ready = 1'b1;
    for (int c = 0; c < 300 && busy; c++) begin
      #1;
      if (done_valid) begin
        chk("drain_done_owed", outst[done_ch], 1);
        outst[done_ch]--;
        n_done++;
      end
      step();
    end
    chk("drain_busy", int'(busy), 0);
    chk("drain_balance", n_done, n_loads);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
